// File: rtl/prefix_pkg.sv
// Shared definitions for the prefix deframer: tag codes, FSM state type and
// the skid-buffer entry layout.
package prefix_pkg;

  localparam logic [1:0] TAG_FILL0 = 2'b00;
  localparam logic [1:0] TAG_FILL1 = 2'b01;
  localparam logic [1:0] TAG_HDR   = 2'b10;
  localparam logic [1:0] TAG_BODY  = 2'b11;

  // Field widths of a skid entry; the deframer's PW/CHW defaults follow these.
  localparam int ENTRY_PW  = 8;
  localparam int ENTRY_CHW = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } state_t;

  typedef struct packed {
    logic [ENTRY_PW-1:0]  data;
    logic [ENTRY_CHW-1:0] chan;
    logic                 last;
  } skid_entry_t;

endpackage

// File: rtl/prefix_deframer_if.sv
// Input {tag,payload} stream and output payload stream of the deframer.
// master = producer/consumer side, slave = deframer side.
interface prefix_deframer_if #(
  parameter int PW  = 8,
  parameter int TW  = 2,
  parameter int CHW = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [TW+PW-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [PW-1:0]     out_data;
  logic [CHW-1:0]    out_chan;
  logic              out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chan, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chan, out_last
  );
endinterface

// File: rtl/prefix_skid2.sv
// Generic 2-entry valid/ready skid buffer. in_ready is a flop driven from the
// next occupancy, so there is no combinational path from out_ready.
module prefix_skid2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   occ;
  logic [1:0]   occ_next;
  logic         do_push;
  logic         do_pop;

  assign do_push   = push && in_ready;
  assign do_pop    = out_valid && out_ready;
  assign out_valid = (occ != 2'd0);
  assign out_data  = mem[rd_ptr];

  always_comb begin
    // NOTE: default assignment first so every path writes occ_next (no latch).
    occ_next = occ;
    if (do_push && !do_pop)
      occ_next = occ + 2'd1;
    else if (do_pop && !do_push)
      occ_next = occ - 2'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: storage is cleared on reset so out_data reads zero while in reset.
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      occ      <= 2'd0;
      in_ready <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop)
        rd_ptr <= ~rd_ptr;
      occ      <= occ_next;
      in_ready <= (occ_next < 2'd2);
    end
  end

endmodule

// File: rtl/prefix_deframer.sv
// Strips {tag,payload} prefixes, reassembles header+counted-body frames and
// streams body payloads with channel/last. Optional: PREFIX_DEFRAMER_STATS_EN.
module prefix_deframer
  import prefix_pkg::*;
#(
  parameter int PW   = ENTRY_PW,
  parameter int TW   = 2,
  parameter int LENW = 4,
  parameter int CHW  = ENTRY_CHW
) (
  input  logic                clk,
  input  logic                rst,
  prefix_deframer_if.slave    bus,
  output logic                err_pulse,
  output logic                busy
`ifdef PREFIX_DEFRAMER_STATS_EN
  ,
  output logic [15:0]         frame_cnt,
  output logic [15:0]         err_cnt
`endif
);

  state_t          state;
  logic [LENW-1:0] cnt;
  logic [CHW-1:0]  chan;

  logic [TW-1:0]   tag;
  logic [PW-1:0]   payload;
  logic [LENW-1:0] hdr_len;
  logic [CHW-1:0]  hdr_chan;
  logic            take;
  logic            push;
  skid_entry_t     push_entry;
  skid_entry_t     pop_entry;

  assign tag      = bus.in_data[TW+PW-1:PW];
  assign payload  = bus.in_data[PW-1:0];
  assign hdr_len  = payload[LENW-1:0];
  assign hdr_chan = payload[LENW+CHW-1:LENW];
  assign take     = bus.in_valid && bus.in_ready;
  assign push     = take && (tag == TAG_BODY) && (state == BODY);

  assign push_entry.data = payload;
  assign push_entry.chan = chan;
  assign push_entry.last = (cnt == LENW'(1));

  assign busy = (state == BODY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      chan      <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (take) begin
        case (tag)
          TAG_FILL0, TAG_FILL1: ;
          TAG_HDR: begin
            // A header mid-frame truncates the old frame; already-pushed words keep last=0.
            chan <= hdr_chan;
            cnt  <= hdr_len;
            if (state == BODY || hdr_len == '0)
              err_pulse <= 1'b1;
            state <= (hdr_len == '0) ? IDLE : BODY;
          end
          TAG_BODY: begin
            if (state == IDLE) begin
              err_pulse <= 1'b1;
            end else begin
              cnt <= cnt - LENW'(1);
              if (cnt == LENW'(1))
                state <= IDLE;
            end
          end
        endcase
      end
    end
  end

  prefix_skid2 #(.W($bits(skid_entry_t))) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .in_ready  (bus.in_ready),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (pop_entry)
  );

  assign bus.out_data = pop_entry.data;
  assign bus.out_chan = pop_entry.chan;
  assign bus.out_last = pop_entry.last;

`ifdef PREFIX_DEFRAMER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= 16'd0;
      err_cnt   <= 16'd0;
    end else begin
      if (bus.out_valid && bus.out_ready && bus.out_last && frame_cnt != 16'hFFFF)
        frame_cnt <= frame_cnt + 16'd1;
      if (err_pulse && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prefix_deframer.sv
// Directed testbench for prefix_deframer; define PREFIX_DEFRAMER_STATS_EN to
// also exercise the statistics counters.
module tb_prefix_deframer;
  import prefix_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        err_pulse;
  logic        busy;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          err_seen = 0;
  logic [10:0] got[$];
`ifdef PREFIX_DEFRAMER_STATS_EN
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;
`endif

  prefix_deframer_if #(.PW(8), .TW(2), .CHW(2)) bus ();

  prefix_deframer #(.PW(8), .TW(2), .LENW(4), .CHW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .err_pulse (err_pulse),
    .busy      (busy)
`ifdef PREFIX_DEFRAMER_STATS_EN
    ,
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Collect output transfers and error pulses half a cycle before the edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready)
        got.push_back({bus.out_data, bus.out_chan, bus.out_last});
      if (err_pulse)
        err_seen++;
    end
  end

  function automatic logic [7:0] hdr(input logic [1:0] ch, input logic [3:0] len);
    return {2'b00, ch, len};
  endfunction

  function automatic logic [10:0] ent(input logic [7:0] d, input logic [1:0] ch, input logic last);
    return {d, ch, last};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one word and return #1 after the edge that accepts it.
  task automatic send(input logic [1:0] tag, input logic [7:0] pl);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = {tag, pl};
    while (bus.in_ready !== 1'b1 && n < 50) begin
      step(1);
      n++;
    end
    n_checks++;
    if (n >= 50) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1 within 50 cycles", bus.in_ready);
    end
    step(1);
    bus.in_valid = 1'b0;
  endtask

  task automatic clear_log();
    got.delete();
    err_seen = 0;
  endtask

  task automatic test_reset();
    step(2);
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_chan, bus.out_last, err_pulse, busy} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h err=%b busy=%b, required all 0",
               bus.in_ready, bus.out_valid, bus.out_data, err_pulse, busy);
    end
    rst = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b, required 0 before first edge", bus.in_ready);
    end
    step(1);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b, required 1", bus.in_ready);
    end

    // Assert reset in the middle of a frame with a word buffered.
    bus.out_ready = 1'b0;
    send(TAG_HDR, hdr(2'd0, 4'd3));
    send(TAG_BODY, 8'h5A);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_chan, bus.out_last, err_pulse, busy} !== 15'd0) begin
      n_fail++;
      $display("FAIL midframe_reset: got rdy=%b vld=%b data=%h chan=%h last=%b busy=%b, required all 0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.out_chan, bus.out_last, busy);
    end
    step(1);
    rst = 1'b0;
    step(1);
    clear_log();
    bus.out_ready = 1'b1;
    send(TAG_HDR, hdr(2'd1, 4'd2));
    send(TAG_BODY, 8'h11);
    send(TAG_BODY, 8'h22);
    step(3);
    n_checks++;
    if (got.size() != 2 || got[0] !== ent(8'h11, 2'd1, 1'b0) || got[1] !== ent(8'h22, 2'd1, 1'b1)) begin
      n_fail++;
      $display("FAIL post_reset_frame: got %0d words, required 2 words 11/ch1/0 and 22/ch1/1", got.size());
    end
    n_checks++;
    if (err_seen != 0) begin
      n_fail++;
      $display("FAIL post_reset_err: got %0d pulses, required 0", err_seen);
    end
  endtask

  task automatic test_nominal();
    logic [10:0] exp_q[$];
    clear_log();
    bus.out_ready = 1'b1;
    send(TAG_HDR, hdr(2'd2, 4'd4));
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL nominal_busy: got %b, required 1", busy);
    end
    for (int i = 0; i < 4; i++) begin
      send(TAG_BODY, 8'hA0 + 8'(i));
      exp_q.push_back(ent(8'hA0 + 8'(i), 2'd2, i == 3));
      n_checks++;
      if (!bus.out_valid || {bus.out_data, bus.out_chan, bus.out_last} !== exp_q[i]) begin
        n_fail++;
        $display("FAIL nominal_latency[%0d]: got vld=%b word=%h, required vld=1 word=%h",
                 i, bus.out_valid, {bus.out_data, bus.out_chan, bus.out_last}, exp_q[i]);
      end
    end
    step(3);
    n_checks++;
    if (got != exp_q) begin
      n_fail++;
      $display("FAIL nominal_stream: got %0d words, required A0..A3 ch2 last on A3", got.size());
    end
    n_checks++;
    if (busy !== 1'b0 || err_seen != 0) begin
      n_fail++;
      $display("FAIL nominal_end: got busy=%b errs=%0d, required busy=0 errs=0", busy, err_seen);
    end
  endtask

  task automatic test_backpressure();
    logic [10:0] exp_q[$];
    clear_log();
    bus.out_ready = 1'b0;
    send(TAG_HDR, hdr(2'd2, 4'd4));
    send(TAG_BODY, 8'hA0);
    send(TAG_BODY, 8'hA1);
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full_ready: got %b, required 0 with 2 buffered", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = {TAG_BODY, 8'hA2};
    step(4);
    n_checks++;
    if (bus.in_ready !== 1'b0 || got.size() != 0) begin
      n_fail++;
      $display("FAIL bp_hold: got rdy=%b outputs=%0d, required rdy=0 outputs=0", bus.in_ready, got.size());
    end
    bus.out_ready = 1'b1;
    send(TAG_BODY, 8'hA2);
    send(TAG_BODY, 8'hA3);
    step(4);
    for (int i = 0; i < 4; i++) exp_q.push_back(ent(8'hA0 + 8'(i), 2'd2, i == 3));
    n_checks++;
    if (got != exp_q) begin
      n_fail++;
      $display("FAIL bp_stream: got %0d words, required A0..A3 in order", got.size());
    end
  endtask

  task automatic test_errors();
    clear_log();
    bus.out_ready = 1'b1;
    send(TAG_BODY, 8'h55);
    n_checks++;
    if (err_pulse !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_body_err: got err=%b vld=%b, required err=1 vld=0", err_pulse, bus.out_valid);
    end
    step(1);
    n_checks++;
    if (err_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL err_width: got %b, required 0 one cycle later", err_pulse);
    end
    send(TAG_HDR, hdr(2'd1, 4'd0));
    n_checks++;
    if (err_pulse !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len_hdr: got err=%b busy=%b, required err=1 busy=0", err_pulse, busy);
    end
    send(TAG_BODY, 8'h66);
    send(TAG_BODY, 8'h77);
    n_checks++;
    if (err_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_err: got %b, required 1", err_pulse);
    end
    step(3);
    n_checks++;
    if (err_seen != 4 || got.size() != 0) begin
      n_fail++;
      $display("FAIL err_totals: got pulses=%0d outputs=%0d, required 4 and 0", err_seen, got.size());
    end
  endtask

  task automatic test_truncation();
    clear_log();
    bus.out_ready = 1'b1;
    send(TAG_FILL0, 8'hC3);
    send(TAG_HDR, hdr(2'd0, 4'd3));
    send(TAG_BODY, 8'hB0);
    send(TAG_FILL1, 8'hFF);
    n_checks++;
    if (busy !== 1'b1 || err_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL filler_in_body: got busy=%b err=%b, required busy=1 err=0", busy, err_pulse);
    end
    send(TAG_HDR, hdr(2'd3, 4'd1));
    n_checks++;
    if (err_pulse !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL trunc_hdr: got err=%b busy=%b, required err=1 busy=1", err_pulse, busy);
    end
    send(TAG_BODY, 8'hB1);
    step(3);
    n_checks++;
    if (got.size() != 2 || got[0] !== ent(8'hB0, 2'd0, 1'b0) || got[1] !== ent(8'hB1, 2'd3, 1'b1)) begin
      n_fail++;
      $display("FAIL trunc_stream: got %0d words, required B0/ch0/0 then B1/ch3/1", got.size());
    end
    n_checks++;
    if (err_seen != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL trunc_end: got errs=%0d busy=%b, required 1 and 0", err_seen, busy);
    end
  endtask

`ifdef PREFIX_DEFRAMER_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    step(1);
    n_checks++;
    if (frame_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_reset: got frames=%0d errs=%0d, required 0 and 0", frame_cnt, err_cnt);
    end
    rst = 1'b0;
    step(1);
    bus.out_ready = 1'b1;
    send(TAG_HDR, hdr(2'd0, 4'd1));
    send(TAG_BODY, 8'h01);
    send(TAG_BODY, 8'hEE);
    send(TAG_HDR, hdr(2'd1, 4'd2));
    send(TAG_BODY, 8'h02);
    send(TAG_BODY, 8'h03);
    send(TAG_HDR, hdr(2'd2, 4'd0));
    send(TAG_HDR, hdr(2'd2, 4'd1));
    send(TAG_BODY, 8'h04);
    step(4);
    n_checks++;
    if (frame_cnt !== 16'd3 || err_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL stats_counts: got frames=%0d errs=%0d, required 3 and 2", frame_cnt, err_cnt);
    end
  endtask
`endif

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_nominal();
    test_backpressure();
    test_errors();
    test_truncation();
`ifdef PREFIX_DEFRAMER_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prefix_deframer.md
Name: prefix_deframer

Overview:
- Receive-side deframer for the tagged concatenation buses that the abc/def-style producers drive, where each word is {tag, payload}, e.g. {1'b1, sig} or {2'b11, sig}.
- Strips and checks the constant prefix, reassembles frames from a header word plus a counted body, and presents payload words on a valid/ready stream with channel and last markers.
- Sits between the producer-side concatenation logic and any consumer that needs the original unprefixed fields.

Parameters:
- PW, 8, payload width in bits.
- TW, 2, tag (prefix) width in bits; fixed at 2 in this revision.
- LENW, 4, width of the frame length field, carried in header payload bits [LENW-1:0].
- CHW, 2, width of the channel id, carried in header payload bits [LENW+CHW-1:LENW]; requires LENW+CHW <= PW.

Ports:
- clk, in, 1, single clock; all state is rising-edge.
- rst, in, 1, asynchronous active-high reset.
- in_valid, in, 1, input word valid.
- in_ready, out, 1, deframer can accept a word.
- in_data, in, TW+PW, {tag, payload}.
- out_valid, out, 1, output word valid.
- out_ready, in, 1, consumer accepts.
- out_data, out, PW, body payload.
- out_chan, out, CHW, channel id from the current frame header.
- out_last, out, 1, final body word of the frame.
- err_pulse, out, 1, one-cycle pulse on a protocol error.
- busy, out, 1, high when the FSM is not in IDLE.

Behaviour:
- Reset is asynchronous and active-high. While rst is asserted, all of the following hold:
  - FSM is in IDLE; length counter, channel register and skid buffer are cleared.
  - out_valid=0, out_data=0, out_chan=0, out_last=0, err_pulse=0, busy=0, in_ready=0.
  - in_ready goes to 1 one cycle after rst deasserts.
- Tag codes:
  - 2'b00 and 2'b01 are filler: always accepted and discarded, in any state.
  - 2'b10 is a header.
  - 2'b11 is a body word.
- A word transfers on a cycle with in_valid && in_ready. Output transfers on out_valid && out_ready.
- Output path is a 2-entry skid buffer:
  - in_ready = (skid occupancy < 2); it is a registered function of occupancy, with no combinational path from out_ready.
  - Latency from accepted body word to out_valid is 1 cycle.
- FSM states: IDLE and BODY.
- IDLE:
  - Header accepted: latch chan and len. If len==0, raise err_pulse and stay in IDLE; otherwise load cnt=len and go to BODY.
  - Body word accepted: raise err_pulse and drop the word.
- BODY:
  - Body word accepted: push {payload, chan, last=(cnt==1)} into the skid buffer and decrement cnt.
  - If cnt==1, go to IDLE after the push.
- BODY, header accepted (truncated frame):
  - Raise err_pulse.
  - If the skid buffer is non-empty, the most recent pushed entry does not get last forced.
  - Restart with the new header: if the new len!=0 stay in BODY, else go to IDLE.
- Filler in BODY is ignored and cnt is held.
- busy = (state==BODY).
- err_pulse is exactly one cycle per offending word. Back-to-back errors produce back-to-back pulses.
- Backpressure: when out_ready is held low, at most 2 body words are buffered, then in_ready=0. No word is lost or duplicated.
- Simultaneous push and pop in the same cycle leaves occupancy unchanged.

Optional Feature:
- Macro: PREFIX_DEFRAMER_STATS_EN.
- When defined, adds these outputs:
  - frame_cnt[15:0]: counts completed frames (out_last transferred).
  - err_cnt[15:0]: counts err_pulse.
  - Both saturate at 16'hFFFF and clear on rst.
- When not defined, the ports and counters are absent. Functional behaviour is otherwise identical.

Decomposition:
- Shared package prefix_pkg holds:
  - Tag localparams: TAG_FILL0=2'b00, TAG_FILL1=2'b01, TAG_HDR=2'b10, TAG_BODY=2'b11.
  - State enum (IDLE, BODY).
  - Skid entry struct {data, chan, last}.
- One sub-module, prefix_skid2: a generic 2-entry valid/ready skid buffer parameterised on entry width.

Test Plan:
- Reset mid-frame: assert rst after header len=3 and 1 body word -> all outputs at reset values within the reset assertion; after release, header len=2 ch=1 followed by 2 bodies -> exactly 2 outputs, the second with out_last=1, no err_pulse.
- Nominal frame: header payload {ch=2, len=4}, then 4 bodies 8'hA0..8'hA3 with out_ready=1 -> outputs A0..A3 with out_chan=2, out_last only on A3, 1-cycle latency.
- Backpressure: same frame with out_ready=0 for 6 cycles -> in_ready drops after 2 bodies buffered; on release, A0..A3 arrive in order with none lost.
- Errors: body word in IDLE -> err_pulse=1 for 1 cycle with no output; header len=0 -> err_pulse and busy stays 0.
- Truncation plus filler: header len=3, 1 body, 2'b01 filler, then header len=1 ch=3, 1 body -> first body out with last=0, err_pulse on the second header, final body out with chan=3 and last=1.
- Stats (macro defined): run 3 good frames and 2 errors -> frame_cnt=3, err_cnt=2.
